// File: rtl/conv_pkg.sv
// Shared types and constants for the conv channel accumulator.
// Latency: n/a (package only).
// Backpressure: n/a.
package conv_pkg;

    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam int          FP_SIGN_BIT  = 31;
    // Address field in the pipeline struct is sized for the largest plane we build.
    localparam int          STAGE_ADDR_W = 16;

    // $clog2 that never returns 0, so a 1-deep or 1-channel build still gets a real counter.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    first;
        logic                    last;
        logic [STAGE_ADDR_W-1:0] addr;
    } stage_t;

endpackage

// File: rtl/acc_ram_sdp.sv
// Simple dual-port accumulation RAM: one write port, one read port with registered data.
// Latency: read data valid 1 cycle after i_re.
// Backpressure: none; a same-address read/write returns the data being written.
// Ports: i_clk/i_rst_n clock and async active-low reset (read register only),
//        i_re/i_raddr/o_rdata read port, i_we/i_waddr/i_wdata write port.
module acc_ram_sdp #(
    parameter int DEPTH  = 612,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Write wins on an address collision: forward the incoming word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fp_add_sub.sv
// FP32 adder/subtractor (round-nearest-even, subnormals flushed to zero).
// Latency: 3 cycles (align, add, normalise/round), 1 result per cycle.
// Backpressure: none; data registers load only on valid beats.
// Ports: i_clk/i_rst_n, i_vld with operands i_a, i_b (i_sub negates i_b), o_vld/o_sum result.
module fp_add_sub (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vld,
    input  logic        i_sub,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_vld,
    output logic [31:0] o_sum
);

    // Stage 1: order by magnitude and align the smaller mantissa (guard/round/sticky in [2:0]).
    logic [31:0] w_b, w_big, w_sml, w_spec_val;
    logic        w_swap, w_spec;
    logic [7:0]  w_d;
    logic [26:0] w_mb, w_ms_raw, w_ms;

    always_comb begin
        w_b      = {i_b[31] ^ i_sub, i_b[30:0]};
        w_swap   = (w_b[30:0] > i_a[30:0]);
        w_big    = w_swap ? w_b : i_a;
        w_sml    = w_swap ? i_a : w_b;
        w_mb     = (w_big[30:23] == 8'd0) ? 27'd0 : {1'b1, w_big[22:0], 3'b000};
        w_ms_raw = (w_sml[30:23] == 8'd0) ? 27'd0 : {1'b1, w_sml[22:0], 3'b000};
        w_d      = w_big[30:23] - w_sml[30:23];
        if (w_d > 8'd26) w_ms = {26'd0, |w_ms_raw};
        else             w_ms = (w_ms_raw >> w_d) | {26'd0, |(w_ms_raw & ~(27'h7FF_FFFF << w_d))};
        // NaN always sorts as the larger magnitude, so only the big operand needs inspecting.
        w_spec = (w_big[30:23] == 8'hFF);
        if ((w_big[22:0] != 23'd0) || ((w_sml[30:23] == 8'hFF) && (w_big[31] != w_sml[31])))
            w_spec_val = 32'h7FC0_0000;
        else
            w_spec_val = w_big;
    end

    logic        r1_vld, r1_sgn, r1_same, r1_spec;
    logic [7:0]  r1_exp;
    logic [26:0] r1_mb, r1_ms;
    logic [31:0] r1_spec_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r1_vld <= 1'b0; r1_sgn <= 1'b0; r1_same <= 1'b0; r1_spec <= 1'b0;
            r1_exp <= '0; r1_mb <= '0; r1_ms <= '0; r1_spec_val <= '0;
        end else begin
            r1_vld <= i_vld;
            if (i_vld) begin
                r1_sgn      <= w_big[31];
                r1_same     <= (w_big[31] == w_sml[31]);
                r1_spec     <= w_spec;
                r1_exp      <= w_big[30:23];
                r1_mb       <= w_mb;
                r1_ms       <= w_ms;
                r1_spec_val <= w_spec_val;
            end
        end
    end

    // Stage 2: magnitude add/subtract; big >= small so the difference is never negative.
    logic        r2_vld, r2_sgn, r2_same, r2_spec;
    logic [7:0]  r2_exp;
    logic [27:0] r2_sum;
    logic [31:0] r2_spec_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r2_vld <= 1'b0; r2_sgn <= 1'b0; r2_same <= 1'b0; r2_spec <= 1'b0;
            r2_exp <= '0; r2_sum <= '0; r2_spec_val <= '0;
        end else begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_sgn      <= r1_sgn;
                r2_same     <= r1_same;
                r2_spec     <= r1_spec;
                r2_exp      <= r1_exp;
                r2_sum      <= r1_same ? ({1'b0, r1_mb} + {1'b0, r1_ms}) : ({1'b0, r1_mb} - {1'b0, r1_ms});
                r2_spec_val <= r1_spec_val;
            end
        end
    end

    // Stage 3: normalise, round to nearest even, pack.
    logic [4:0]  w_msb, w_lz;
    logic [26:0] w_m;
    logic [9:0]  w_e, w_e2;
    logic [24:0] w_rnd;
    logic        w_up;
    logic [31:0] w_res;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < 27; i++) begin
            if (r2_sum[i]) w_msb = 5'(i);
        end
        w_lz = 5'd26 - w_msb;
        if (r2_sum[27]) begin
            w_m = {r2_sum[27:2], |r2_sum[1:0]};
            w_e = {2'b00, r2_exp} + 10'd1;
        end else begin
            w_m = r2_sum[26:0] << w_lz;
            w_e = {2'b00, r2_exp} - {5'd0, w_lz};
        end
        w_up  = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
        w_rnd = {1'b0, w_m[26:3]} + {24'd0, w_up};
        w_e2  = w_e + {9'd0, w_rnd[24]};
        if (r2_spec)                    w_res = r2_spec_val;
        else if (r2_sum == 28'd0)       w_res = {r2_sgn & r2_same, 31'd0};
        else if (w_e[9] || w_e == 10'd0) w_res = {r2_sgn, 31'd0};
        else if (w_e2 >= 10'd255)       w_res = {r2_sgn, 8'hFF, 23'd0};
        else                            w_res = {r2_sgn, w_e2[7:0], w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0]};
    end

    logic        r3_vld;
    logic [31:0] r3_res;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r3_vld <= 1'b0;
            r3_res <= '0;
        end else begin
            r3_vld <= r2_vld;
            if (r2_vld) r3_res <= w_res;
        end
    end

    assign o_vld = r3_vld;
    assign o_sum = r3_res;

endmodule

// File: rtl/conv_channel_accumulator.sv
// Streaming cross-channel FP32 adder: sums each pixel position over CHANNEL_NUM_IN channel planes.
// Latency: 1+ADD_LATENCY cycles valid_in -> valid_out, 1 pixel/cycle, no idle between frames.
// Backpressure: none; i_clear aborts the frame and drops in-flight data.
// Ports: i_clk, i_rst_n (async active-low), i_clear, i_valid_in/i_pxl_in in;
//        o_pxl_out/o_valid_out/o_frame_done result, o_ch_idx channel being accepted.
// Optional: define CONV_CHANNEL_ACC_RELU_EN to apply ReLU to the final sum only.
module conv_channel_accumulator
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNEL_NUM_IN = 64,
    parameter int IMAGE_SIZE     = 612,
    parameter int ADD_LATENCY    = 3,
    parameter int PXL_CNT_W      = clog2_safe(IMAGE_SIZE),
    parameter int CH_CNT_W       = clog2_safe(CHANNEL_NUM_IN + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid_in,
    input  logic [DATA_WIDTH-1:0] i_pxl_in,
    output logic [DATA_WIDTH-1:0] o_pxl_out,
    output logic                  o_valid_out,
    output logic                  o_frame_done,
    output logic [CH_CNT_W-1:0]   o_ch_idx
);

    logic                  w_accept, w_pxl_wrap, w_ch_wrap;
    logic [PXL_CNT_W-1:0]  r_pxl_cnt;
    logic [CH_CNT_W-1:0]   r_ch_cnt;

    assign w_accept   = i_valid_in & ~i_clear;
    assign w_pxl_wrap = (r_pxl_cnt == PXL_CNT_W'(IMAGE_SIZE - 1));
    assign w_ch_wrap  = (r_ch_cnt == CH_CNT_W'(CHANNEL_NUM_IN - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pxl_cnt <= '0;
            r_ch_cnt  <= '0;
        end else if (i_clear) begin
            r_pxl_cnt <= '0;
            r_ch_cnt  <= '0;
        end else if (i_valid_in) begin
            if (w_pxl_wrap) begin
                r_pxl_cnt <= '0;
                r_ch_cnt  <= w_ch_wrap ? '0 : r_ch_cnt + CH_CNT_W'(1);
            end else begin
                r_pxl_cnt <= r_pxl_cnt + PXL_CNT_W'(1);
            end
        end
    end

    // S0 -> S1: capture the pixel and its bookkeeping while the RAM read is in flight.
    stage_t                r_s1;
    logic [DATA_WIDTH-1:0] r_s1_pxl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= '0;
            r_s1_pxl <= '0;
        end else begin
            r_s1.valid <= w_accept;
            if (w_accept) begin
                r_s1.first <= (r_ch_cnt == '0);
                r_s1.last  <= w_ch_wrap;
                r_s1.addr  <= STAGE_ADDR_W'(r_pxl_cnt);
                r_s1_pxl   <= i_pxl_in;
            end
        end
    end

    // Bookkeeping rides alongside the adder; its valids are the ones clear kills.
    stage_t r_meta [ADD_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ADD_LATENCY; i++) r_meta[i] <= '0;
        end else begin
            r_meta[0]       <= r_s1;
            r_meta[0].valid <= r_s1.valid & ~i_clear;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                r_meta[i]       <= r_meta[i-1];
                r_meta[i].valid <= r_meta[i-1].valid & ~i_clear;
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_rd_dat, w_op_b, w_sum, w_final;
    logic                  w_add_vld, w_vld_fin, w_wr_en;

    // Channel 0 starts from zero so stale RAM contents never leak into a new frame.
    assign w_op_b = r_s1.first ? FP_ZERO : w_rd_dat;

    fp_add_sub u_add (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (r_s1.valid),
        .i_sub   (1'b0),
        .i_a     (r_s1_pxl),
        .i_b     (w_op_b),
        .o_vld   (w_add_vld),
        .o_sum   (w_sum)
    );

    assign w_vld_fin = r_meta[ADD_LATENCY-1].valid & w_add_vld & ~i_clear;
    // The last channel's sum goes straight out; no need to write it back.
    assign w_wr_en   = w_vld_fin & ~r_meta[ADD_LATENCY-1].last;

    acc_ram_sdp #(
        .DEPTH  (IMAGE_SIZE),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (PXL_CNT_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_re    (w_accept),
        .i_raddr (r_pxl_cnt),
        .o_rdata (w_rd_dat),
        .i_we    (w_wr_en),
        .i_waddr (r_meta[ADD_LATENCY-1].addr[PXL_CNT_W-1:0]),
        .i_wdata (w_sum)
    );

`ifdef CONV_CHANNEL_ACC_RELU_EN
    // Any set sign bit (including -0.0) clamps to +0.
    assign w_final = w_sum[FP_SIGN_BIT] ? FP_ZERO : w_sum;
`else
    assign w_final = w_sum;
`endif

    assign o_valid_out  = w_vld_fin & r_meta[ADD_LATENCY-1].last;
    assign o_frame_done = o_valid_out & (r_meta[ADD_LATENCY-1].addr == STAGE_ADDR_W'(IMAGE_SIZE - 1));

    // Intermediate sums also leave the adder, so the output holds the last final sum between beats.
    logic [DATA_WIDTH-1:0] r_pxl_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         r_pxl_hold <= '0;
        else if (o_valid_out) r_pxl_hold <= w_final;
    end

    assign o_pxl_out = o_valid_out ? w_final : r_pxl_hold;
    assign o_ch_idx  = r_ch_cnt;

endmodule
